// File: rtl/gpio_in_debounce.sv
// Switch/button input conditioner: per-bit 2-FF synchronizer, prescaled debounce filter,
// edge pulses and change strobe. Define GPIO_DEB_EVENT_LATCH_EN for sticky W1C event flags.
module gpio_in_debounce #(
   parameter int               WIDTH        = 16,
   parameter int               TICK_DIV     = 100000,
   parameter int               STABLE_TICKS = 8,
   parameter logic [WIDTH-1:0] RESET_VAL    = '0
) (
   input  logic             clk_i,
   input  logic             arst_n_i,
   input  logic [WIDTH-1:0] raw_i,
   output logic [WIDTH-1:0] filt_o,
   output logic [WIDTH-1:0] rise_o,
   output logic [WIDTH-1:0] fall_o,
   output logic             change_o,
   output logic [WIDTH-1:0] evt_o,
   input  logic [WIDTH-1:0] evt_ack_i,
   output logic             irq_o
);

   localparam int             PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int             CW     = $clog2(STABLE_TICKS);
   localparam logic [PW-1:0]  P_LAST = PW'(TICK_DIV - 1);
   localparam logic [CW-1:0]  C_LAST = CW'(STABLE_TICKS - 1);

   logic [WIDTH-1:0] r_sync1;
   logic [WIDTH-1:0] r_sync2;
   logic [PW-1:0]    r_pcnt;
   logic [CW-1:0]    r_cnt [WIDTH];
   logic [WIDTH-1:0] r_filt;
   logic [WIDTH-1:0] r_rise;
   logic [WIDTH-1:0] r_fall;
   logic             r_change;

   logic             w_tick;
   logic [WIDTH-1:0] w_diff;
   logic [WIDTH-1:0] w_accept;

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         r_sync1 <= RESET_VAL;
         r_sync2 <= RESET_VAL;
      end else begin
         r_sync1 <= raw_i;
         r_sync2 <= r_sync1;
      end
   end

   // Free-running prescaler; with TICK_DIV=1 P_LAST is 0 and the tick fires every cycle.
   assign w_tick = (r_pcnt == P_LAST);

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         r_pcnt <= '0;
      end else if (w_tick) begin
         r_pcnt <= '0;
      end else begin
         r_pcnt <= r_pcnt + PW'(1);
      end
   end

   assign w_diff = r_sync2 ^ r_filt;

   always_comb begin
      w_accept = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_accept[i] = w_diff[i] & w_tick & (r_cnt[i] == C_LAST);
      end
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         for (int i = 0; i < WIDTH; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (!w_diff[i] || w_accept[i]) begin
               r_cnt[i] <= '0;
            end else if (w_tick) begin
               r_cnt[i] <= r_cnt[i] + CW'(1);
            end
         end
      end
   end

   // Pulses are registered alongside filt so they mark the first cycle of the new level.
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         r_filt   <= RESET_VAL;
         r_rise   <= '0;
         r_fall   <= '0;
         r_change <= 1'b0;
      end else begin
         r_filt   <= r_filt ^ w_accept;
         r_rise   <= w_accept & r_sync2;
         r_fall   <= w_accept & ~r_sync2;
         r_change <= |w_accept;
      end
   end

   assign filt_o   = r_filt;
   assign rise_o   = r_rise;
   assign fall_o   = r_fall;
   assign change_o = r_change;

`ifdef GPIO_DEB_EVENT_LATCH_EN
   logic [WIDTH-1:0] r_evt;

   // A new edge outranks an acknowledge landing on the same bit.
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         r_evt <= '0;
      end else begin
         r_evt <= (r_evt & ~evt_ack_i) | r_rise | r_fall;
      end
   end

   assign evt_o = r_evt;
   assign irq_o = |r_evt;
`else
   logic w_unused_ack;

   assign w_unused_ack = ^evt_ack_i;
   assign evt_o        = '0;
   assign irq_o        = r_change;
`endif

endmodule

// File: tb/tb_gpio_in_debounce.sv
// Self-checking bench for gpio_in_debounce (WIDTH=16, TICK_DIV=4, STABLE_TICKS=3).
// Expected edge pulses are queued when stimulus is driven and checked by a monitor.
module tb_gpio_in_debounce;

   localparam int W    = 16;
   localparam int LMIN = 11;
   localparam int LMAX = 14;

   logic          clk_i     = 1'b0;
   logic          arst_n_i  = 1'b0;
   logic [W-1:0]  raw_i     = '0;
   logic [W-1:0]  evt_ack_i = '0;
   logic [W-1:0]  filt_o;
   logic [W-1:0]  rise_o;
   logic [W-1:0]  fall_o;
   logic          change_o;
   logic [W-1:0]  evt_o;
   logic          irq_o;

   gpio_in_debounce #(
      .WIDTH        (W),
      .TICK_DIV     (4),
      .STABLE_TICKS (3),
      .RESET_VAL    ('0)
   ) dut (
      .clk_i     (clk_i),
      .arst_n_i  (arst_n_i),
      .raw_i     (raw_i),
      .filt_o    (filt_o),
      .rise_o    (rise_o),
      .fall_o    (fall_o),
      .change_o  (change_o),
      .evt_o     (evt_o),
      .evt_ack_i (evt_ack_i),
      .irq_o     (irq_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [W-1:0] rise;
      logic [W-1:0] fall;
      int           tmin;
      int           tmax;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   vectors     = 0;
   int   miscompares = 0;
   int   cyc         = 0;
   logic exp_chg;

   always @(posedge clk_i) cyc <= cyc + 1;

   always @(negedge clk_i) begin
      if (arst_n_i) begin
         exp_chg = ((rise_o | fall_o) != '0);
         if (exp_chg) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_pulse: rise=%h fall=%h at cycle %0d, required no pulse", rise_o, fall_o, cyc);
            end else begin
               mon_e = exp_q.pop_front();
               if (rise_o !== mon_e.rise || fall_o !== mon_e.fall) begin
                  miscompares++;
                  $display("FAIL pulse_value: rise=%h fall=%h, required rise=%h fall=%h", rise_o, fall_o, mon_e.rise, mon_e.fall);
               end
               vectors++;
               if (cyc < mon_e.tmin || cyc > mon_e.tmax) begin
                  miscompares++;
                  $display("FAIL pulse_latency: cycle %0d, required %0d..%0d", cyc, mon_e.tmin, mon_e.tmax);
               end
            end
         end
         vectors++;
         if (change_o !== exp_chg) begin
            miscompares++;
            $display("FAIL change_strobe: change_o=%b at cycle %0d, required %b", change_o, cyc, exp_chg);
         end
`ifndef GPIO_DEB_EVENT_LATCH_EN
         vectors++;
         if (irq_o !== exp_chg) begin
            miscompares++;
            $display("FAIL irq_follows_change: irq_o=%b at cycle %0d, required %b", irq_o, cyc, exp_chg);
         end
`endif
      end
   end

   task automatic push_exp(input logic [W-1:0] r, input logic [W-1:0] f);
      exp_t e;
      e.rise = r;
      e.fall = f;
      e.tmin = cyc + LMIN;
      e.tmax = cyc + LMAX;
      exp_q.push_back(e);
   endtask

   task automatic wait_idle(input int budget);
      for (int k = 0; k < budget && exp_q.size() != 0; k++) @(negedge clk_i);
      repeat (3) @(negedge clk_i);
   endtask

   task automatic test_reset();
      @(negedge clk_i);
      arst_n_i = 1'b0;
      raw_i    = 16'hFFFF;
      repeat (2) @(negedge clk_i);
      vectors++;
      if ({filt_o, rise_o, fall_o, change_o, evt_o, irq_o} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: filt=%h rise=%h fall=%h chg=%b evt=%h irq=%b, required all 0",
                  filt_o, rise_o, fall_o, change_o, evt_o, irq_o);
      end
      arst_n_i = 1'b1;
      push_exp(16'hFFFF, 16'h0000);
      wait_idle(30);
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL reset_release_timeout: %0d pulses pending, required 0", exp_q.size());
         exp_q.delete();
      end
      vectors++;
      if (filt_o !== 16'hFFFF) begin
         miscompares++;
         $display("FAIL reset_release_filt: filt=%h, required FFFF", filt_o);
      end
      raw_i = 16'h0000;
      push_exp(16'h0000, 16'hFFFF);
      wait_idle(30);
      vectors++;
      if (exp_q.size() != 0 || filt_o !== 16'h0000) begin
         miscompares++;
         $display("FAIL all_fall: filt=%h pending=%0d, required filt 0000 pending 0", filt_o, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_clean_step();
      raw_i[0] = 1'b1;
      push_exp(16'h0001, 16'h0000);
      wait_idle(30);
      vectors++;
      if (exp_q.size() != 0 || filt_o !== 16'h0001) begin
         miscompares++;
         $display("FAIL clean_step: filt=%h pending=%0d, required filt 0001 pending 0", filt_o, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_glitch();
      raw_i[3] = 1'b1;
      repeat (6) @(negedge clk_i);
      raw_i[3] = 1'b0;
      repeat (20) @(negedge clk_i);
      vectors++;
      if (filt_o !== 16'h0001) begin
         miscompares++;
         $display("FAIL glitch_filt: filt=%h, required 0001", filt_o);
      end
      raw_i[3] = 1'b1;
      push_exp(16'h0008, 16'h0000);
      wait_idle(30);
      vectors++;
      if (exp_q.size() != 0 || filt_o !== 16'h0009) begin
         miscompares++;
         $display("FAIL glitch_then_step: filt=%h pending=%0d, required filt 0009 pending 0", filt_o, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_bounce();
      for (int i = 0; i < 13; i++) begin
         raw_i[5] = ~raw_i[5];
         if (i == 12) push_exp(16'h0020, 16'h0000);
         repeat (3) @(negedge clk_i);
      end
      wait_idle(30);
      vectors++;
      if (exp_q.size() != 0 || filt_o !== 16'h0029) begin
         miscompares++;
         $display("FAIL bounce: filt=%h pending=%0d, required filt 0029 pending 0", filt_o, exp_q.size());
         exp_q.delete();
      end
   endtask

`ifdef GPIO_DEB_EVENT_LATCH_EN
   task automatic test_events();
      bit seen;
      raw_i[2:1] = 2'b11;
      push_exp(16'h0006, 16'h0000);
      wait_idle(30);
      vectors++;
      if (exp_q.size() != 0 || evt_o !== 16'h0006 || irq_o !== 1'b1) begin
         miscompares++;
         $display("FAIL evt_set: evt=%h irq=%b pending=%0d, required evt 0006 irq 1", evt_o, irq_o, exp_q.size());
         exp_q.delete();
      end
      evt_ack_i = 16'h0002;
      @(negedge clk_i);
      evt_ack_i = '0;
      vectors++;
      if (evt_o !== 16'h0004 || irq_o !== 1'b1) begin
         miscompares++;
         $display("FAIL evt_ack: evt=%h irq=%b, required evt 0004 irq 1", evt_o, irq_o);
      end
      raw_i[2] = 1'b0;
      push_exp(16'h0000, 16'h0004);
      seen = 1'b0;
      for (int k = 0; k < 30 && !seen; k++) begin
         @(negedge clk_i);
         seen = fall_o[2];
      end
      vectors++;
      if (!seen) begin
         miscompares++;
         $display("FAIL evt_fall_timeout: fall_o[2]=%b, required 1", fall_o[2]);
      end
      evt_ack_i = 16'h0004;
      @(negedge clk_i);
      evt_ack_i = '0;
      vectors++;
      if (evt_o !== 16'h0004 || irq_o !== 1'b1) begin
         miscompares++;
         $display("FAIL evt_set_wins: evt=%h irq=%b, required evt 0004 irq 1", evt_o, irq_o);
      end
      evt_ack_i = 16'h0004;
      @(negedge clk_i);
      evt_ack_i = '0;
      vectors++;
      if (evt_o !== 16'h0000 || irq_o !== 1'b0 || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL evt_clear: evt=%h irq=%b pending=%0d, required evt 0000 irq 0", evt_o, irq_o, exp_q.size());
         exp_q.delete();
      end
   endtask
`endif

   task automatic test_mid_reset();
      raw_i[7] = 1'b1;
      repeat (9) @(negedge clk_i);
      arst_n_i = 1'b0;
      @(negedge clk_i);
      vectors++;
      if ({filt_o, rise_o, fall_o, change_o} !== '0) begin
         miscompares++;
         $display("FAIL mid_reset_outputs: filt=%h rise=%h fall=%h chg=%b, required all 0", filt_o, rise_o, fall_o, change_o);
      end
      @(negedge clk_i);
      arst_n_i = 1'b1;
      push_exp(raw_i, 16'h0000);
      wait_idle(30);
      vectors++;
      if (exp_q.size() != 0 || filt_o !== raw_i) begin
         miscompares++;
         $display("FAIL mid_reset_restart: filt=%h pending=%0d, required filt %h pending 0", filt_o, exp_q.size(), raw_i);
         exp_q.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_clean_step();
      test_glitch();
      test_bounce();
`ifdef GPIO_DEB_EVENT_LATCH_EN
      test_events();
`endif
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
